// File: rtl/riscv_apb_pkg.sv
// rtl/riscv_apb_pkg.sv - shared types and constants for the APB memory completer
package riscv_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READY = 2'b10
    } apb_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/riscv_apb_mem_array.sv
// rtl/riscv_apb_mem_array.sv - word storage with byte-enabled write and asynchronous read
module riscv_apb_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write; contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/riscv_apb_mem.sv
// rtl/riscv_apb_mem.sv - APB completer fronting a word-addressed memory with fixed wait states
module riscv_apb_mem
    import riscv_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    // One past the last valid byte address, kept 33 bits wide so a window
    // ending at 2^32 does not wrap around
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic [31:0]      wdata_q;
    logic [3:0]       strb_q;
    logic             err_q;
    logic [31:0]      prdata_q;

    logic             setup;
    logic             addr_err;
    logic [IDX_W-1:0] setup_idx;
    logic [31:0]      mem_rdata;
    logic             mem_we;

    assign setup     = (state_q == ST_IDLE) && psel_i && !penable_i;
    assign addr_err  = (paddr_i[1:0] != 2'b00)
                    || ({1'b0, paddr_i} < {1'b0, BASE_ADDR})
                    || ({1'b0, paddr_i} >= ADDR_LIMIT);
    // Only meaningful when addr_err is clear, i.e. the address is aligned and inside the window
    assign setup_idx = paddr_i[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    // Reset gating keeps a reset that lands right at the completing edge from committing
    assign mem_we    = (state_q == ST_READY) && psel_i && penable_i
                    && write_q && !err_q && !reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: setup -> optional wait states -> ready -> idle; dropping psel aborts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d = (WAIT_CYCLES != 0) ? ST_WAIT : ST_READY;
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so no input reaches them combinationally
    always_comb begin
        pready_o  = (state_q == ST_READY);
        pslverr_o = (state_q == ST_READY) && err_q;
        prdata_o  = prdata_q;
    end

    // Wait-state counter, loaded at setup and counting down through ST_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (setup) begin
            cnt_q <= WAIT_LOAD;
        end else if (state_q == ST_WAIT && psel_i) begin
            cnt_q <= cnt_q - 4'd1;
        end else begin
            cnt_q <= 4'd0;
        end
    end

    // Transfer capture at setup; read data is fetched here and held until the next read setup
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            strb_q   <= 4'h0;
            err_q    <= 1'b0;
            prdata_q <= 32'h0;
        end else if (setup) begin
            idx_q   <= setup_idx;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            err_q   <= addr_err;
            if (!pwrite_i) begin
                prdata_q <= addr_err ? 32'h0 : mem_rdata;
            end
        end
    end

    riscv_apb_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_idx (idx_q),
        .wr_data(wdata_q),
        .wr_strb(strb_q),
        .rd_idx (setup_idx),
        .rd_data(mem_rdata)
    );

endmodule

// File: doc/riscv_apb_mem.md
RISCV_APB_MEM -- requirements
Module: riscv_apb_mem

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-high, with ports named clk and reset.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-003 Parameter DEPTH_WORDS, default 1024: number of 32-bit words (power of two, 2..65536).
REQ-004 Parameter WAIT_CYCLES, default 1: access-phase cycles with pready_o low before completion (0..15).
REQ-005 Ports SHALL be, in order:
- clk  input  1  clock
- reset  input  1  async active-high reset
- psel_i  input  1  APB select
- penable_i  input  1  APB access phase
- paddr_i  input  32  byte address
- pwrite_i  input  1  1 = write, 0 = read
- pwdata_i  input  32  write data
- pstrb_i  input  4  byte write strobes (bit n = byte lane n)
- pready_o  output  1  transfer completes this cycle
- prdata_o  output  32  read data
- pslverr_o  output  1  error response, valid only while pready_o = 1

Function
REQ-006 The block SHALL be an APB completer, with states ST_IDLE, ST_WAIT and ST_READY.
REQ-007 Setup SHALL be detected in ST_IDLE as psel_i=1 and penable_i=0; at that edge it captures paddr_i, pwrite_i, pwdata_i and pstrb_i, and computes the error flag.
REQ-008 The error flag SHALL be set when paddr_i[1:0]!=0 or paddr_i is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); the comparison is unsigned 32-bit and performed without overflow.
REQ-009 On a setup edge, the next state SHALL be ST_WAIT with the counter loaded to WAIT_CYCLES if WAIT_CYCLES>0, else ST_READY.
REQ-010 In ST_WAIT, pready_o SHALL be 0; the counter decrements each cycle; at counter==1 the next state is ST_READY.
REQ-011 In ST_READY, pready_o SHALL be 1 combinationally from state; the access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
REQ-012 For reads, prdata_o SHALL be registered at the setup edge with mem[(paddr_i-BASE_ADDR)>>2], or with 0 on error; it holds until the next read setup.
REQ-013 A write SHALL commit on the ST_READY edge with psel_i=penable_i=1 and error=0: only bytes whose pstrb_i bit is 1 are updated; pstrb_i is ignored for reads.
REQ-014 pslverr_o SHALL equal the captured error flag in ST_READY and be 0 in all other states.
REQ-015 From ST_READY, the next state SHALL be ST_IDLE, so a setup in the following cycle is accepted (back-to-back transfers).
REQ-016 If psel_i=0 in ST_WAIT or ST_READY (protocol violation), the block SHALL abort to ST_IDLE with no write.
REQ-017 In ST_IDLE, psel_i=1 with penable_i=1 SHALL be ignored: no capture and no response.
REQ-018 There SHALL be no combinational path from any APB input to pready_o, prdata_o or pslverr_o.

Reset
REQ-019 On reset, the state SHALL be ST_IDLE, the counter 0, pready_o 0, prdata_o 32'h0, pslverr_o 0 and all captured registers 0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 A reset asserted mid-transfer, including in ST_READY, SHALL abort the transfer with no write performed.

Structure
REQ-022 Package riscv_apb_pkg SHALL hold the completer state enum (2-bit, ST_IDLE=2'b00, ST_WAIT=2'b01, ST_READY=2'b10) and the default BASE_ADDR constant.
REQ-023 Storage SHALL be a sub-module riscv_apb_mem_array: synchronous byte-enabled write, read port, word index width $clog2(DEPTH_WORDS).

Verification (WAIT_CYCLES=2 unless stated)
REQ-024 Write 32'hDEADBEEF to 8000_0004 with pstrb 4'hF -> pready_o low for 2 access cycles, high in the 3rd, pslverr_o=0; a following read returns 32'hDEADBEEF.
REQ-025 Write 32'h0000AB00 to 8000_0004 with pstrb 4'b0010, then read -> 32'hDEADABEF.
REQ-026 Read 7FFF_FFFC, then read 8000_1000 (DEPTH_WORDS=1024) -> each completes after 3 access cycles with pslverr_o=1 and prdata_o=0.
REQ-027 Misaligned write 32'h1234_5678 to 8000_0006 -> pslverr_o=1; a read of 8000_0004 still returns 32'hDEADABEF.
REQ-028 Reset pulsed during ST_WAIT of a write of 32'h1111_1111 to 8000_0008 (previously 0) -> all outputs 0 immediately; a later read returns 0.
REQ-029 WAIT_CYCLES=0: back-to-back setups with no idle cycle between them -> pready_o=1 in the first access cycle of each transfer, with correct data for both.
